// File: rtl/cpu_types_pkg.sv
// Shared core types: machine word and the fetch-stage state encoding.
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN, HALTED} fetch_state_t;

  localparam word_t PC_INIT_DEF = 32'h0000_0000;

  // Branch/jump targets are always word aligned.
  function automatic word_t align_pc(input word_t a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry skid register holding a fetched instruction and its PC+4
// while IF/ID is stalled.
module fetch_hold_buf
  import cpu_types_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  load_i,
  input  logic  clear_i,
  input  word_t instr_i,
  input  word_t pc4_i,
  output word_t instr_o,
  output word_t pc4_o
);
  word_t instr_q, pc4_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      instr_q <= '0;
      pc4_q   <= '0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc4_q   <= pc4_i;
    end
  end

  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;
endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, icache request, IF/ID handoff, and
// handling of misses, stalls, redirects and halt.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = PC_INIT_DEF
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  ihit,
  input  word_t imemload,
  output logic  iREN,
  output word_t imemaddr,
  input  logic  stall,
  input  logic  redirect,
  input  word_t redirect_pc,
  input  logic  halt,
  output word_t instr_o,
  output word_t pc_4_o,
  output logic  if_valid,
  output word_t fetch_count
);
  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d, pend_q, pend_d, cnt_q, cnt_d;
  word_t        pc_plus4, tgt, hold_instr, hold_pc4;
  logic         hold_ld, hold_clr;

  assign pc_plus4 = pc_q + 32'd4;
  assign tgt      = align_pc(redirect_pc);

  fetch_hold_buf u_hold (
    .clk_i   (CLK),
    .rst_ni  (nRST),
    .load_i  (hold_ld),
    .clear_i (hold_clr),
    .instr_i (imemload),
    .pc4_i   (pc_plus4),
    .instr_o (hold_instr),
    .pc4_o   (hold_pc4)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pend_d   = pend_q;
    cnt_d    = cnt_q;
    hold_ld  = 1'b0;
    hold_clr = 1'b0;
    iREN     = 1'b0;
    imemaddr = pc_q;
    instr_o  = '0;
    pc_4_o   = '0;
    if_valid = 1'b0;
    unique case (state_q)
      FETCH: begin
        iREN    = 1'b1;
        instr_o = imemload;
        pc_4_o  = pc_plus4;
        if (halt) begin
          state_d = HALTED;
        end else if (redirect) begin
          // A hit under redirect is a wrong-path word: drop it.
          if (ihit) pc_d = tgt;
          else begin
            pend_d  = tgt;
            state_d = DRAIN;
          end
        end else if (ihit) begin
          if_valid = 1'b1;
          pc_d     = pc_plus4;
          if (stall) begin
            hold_ld = 1'b1;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      end
      HOLD: begin
        instr_o = hold_instr;
        pc_4_o  = hold_pc4;
        if (halt) begin
          hold_clr = 1'b1;
          state_d  = HALTED;
        end else if (redirect) begin
          pc_d    = tgt;
          state_d = FETCH;
        end else begin
          if_valid = 1'b1;
          if (!stall) begin
            cnt_d   = cnt_q + 32'd1;
            state_d = FETCH;
          end
        end
      end
      DRAIN: begin
        // Keep the old request up so the outstanding miss can retire.
        iREN = 1'b1;
        if (halt) begin
          state_d = HALTED;
        end else if (redirect) begin
          if (ihit) begin
            pc_d    = tgt;
            state_d = FETCH;
          end else begin
            pend_d = tgt;
          end
        end else if (ihit) begin
          pc_d    = pend_q;
          state_d = FETCH;
        end
      end
      HALTED: ;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= FETCH;
      pc_q    <= PC_INIT;
      pend_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fetch_count = cnt_q;
endmodule
